// File: rtl/portgroup_rx_frame.sv
// portgroup_rx_frame
//   Upstream receive framer for the port group RX path. Assembles two-beat
//   frames from an SOF-marked beat stream, buffers up to two completed frames
//   in order, and presents the head frame to the core-side RX data inputs.
//   Framing errors are counted in a saturating counter.
//
// Ports:
//   main_clk_i   clock
//   main_rst_i   synchronous active-high reset
//   ena_i        capture enable (register-file control enable)
//   in_valid_i   beat valid
//   in_ready_o   beat ready (ena_i and not full; 0 while in reset)
//   in_data_i    beat data
//   in_sof_i     beat is first beat of a frame
//   rx_valid_o   head frame present
//   rx_data0_o   head frame beat 0 (0 when empty)
//   rx_data1_o   head frame beat 1 (0 when empty)
//   rx_pop_i     consume head frame (ignored when empty)
//   err_cnt_o    saturating framing-error count
module portgroup_rx_frame #(
   parameter int unsigned width_p        = 8,
   parameter int unsigned errcnt_width_p = 8
) (
   input  logic                      main_clk_i,
   input  logic                      main_rst_i,
   input  logic                      ena_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [width_p-1:0]        in_data_i,
   input  logic                      in_sof_i,
   output logic                      rx_valid_o,
   output logic [width_p-1:0]        rx_data0_o,
   output logic [width_p-1:0]        rx_data1_o,
   input  logic                      rx_pop_i,
   output logic [errcnt_width_p-1:0] err_cnt_o
);

   typedef enum logic {
      WAIT_SOF,
      WAIT_SECOND
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [width_p-1:0]     hold;
   logic [2*width_p-1:0]   fifo_mem [2];
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0]             count;
   logic [1:0]             count_nxt;
   logic                   full;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   err_evt;
   logic                   hold_load;

   // Ready sees only the enable and the registered full flag; reset forces it low.
   assign in_ready_o = ena_i & ~full & ~main_rst_i;
   assign accept     = in_valid_i & in_ready_o;
   assign rx_valid_o = (count != 2'd0);
   assign pop        = rx_pop_i & rx_valid_o;
   assign count_nxt  = count + {1'b0, push} - {1'b0, pop};

   assign rx_data0_o = rx_valid_o ? fifo_mem[rd_ptr][2*width_p-1:width_p] : '0;
   assign rx_data1_o = rx_valid_o ? fifo_mem[rd_ptr][width_p-1:0]         : '0;

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         state <= WAIT_SOF;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      err_evt   = 1'b0;
      hold_load = 1'b0;
      case (state)
         WAIT_SOF: begin
            if (accept) begin
               if (in_sof_i) begin
                  hold_load = 1'b1;
                  state_nxt = WAIT_SECOND;
               end else begin
                  err_evt = 1'b1;
               end
            end
         end
         WAIT_SECOND: begin
            // Losing the enable abandons the partial frame silently.
            if (!ena_i) begin
               state_nxt = WAIT_SOF;
            end else if (accept) begin
               if (in_sof_i) begin
                  err_evt   = 1'b1;
                  hold_load = 1'b1;
               end else begin
                  push      = 1'b1;
                  state_nxt = WAIT_SOF;
               end
            end
         end
         default: state_nxt = WAIT_SOF;
      endcase
   end

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         hold      <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         full      <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         if (hold_load) begin
            hold <= in_data_i;
         end
         if (push) begin
            fifo_mem[wr_ptr] <= {hold, in_data_i};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_nxt;
         full  <= (count_nxt == 2'd2);
         if (err_evt && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_portgroup_rx_frame.sv
module tb_portgroup_rx_frame;

   localparam int W    = 8;
   localparam int EW   = 3;
   localparam int EMAX = (1 << EW) - 1;

   logic          clk;
   logic          rst;
   logic          ena;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_sof;
   logic          rx_valid;
   logic [W-1:0]  rx_data0;
   logic [W-1:0]  rx_data1;
   logic          rx_pop;
   logic [EW-1:0] err_cnt;

   portgroup_rx_frame #(
      .width_p        (W),
      .errcnt_width_p (EW)
   ) dut (
      .main_clk_i (clk),
      .main_rst_i (rst),
      .ena_i      (ena),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .in_sof_i   (in_sof),
      .rx_valid_o (rx_valid),
      .rx_data0_o (rx_data0),
      .rx_data1_o (rx_data1),
      .rx_pop_i   (rx_pop),
      .err_cnt_o  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: frames held, partial-frame memory, error count.
   int          total = 0;
   int          bad   = 0;
   bit          started = 0;
   int          cur_occ = 0;
   int          cur_err = 0;
   bit          have_first = 0;
   logic [W-1:0] first_beat = '0;
   logic [2*W-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares outputs at the falling edge, pops scoreboard on consume.
   always @(negedge clk) begin
      if (started) begin
         check("in_ready", {31'b0, in_ready}, {31'b0, (ena && !rst && cur_occ < 2)});
         check("rx_valid", {31'b0, rx_valid}, {31'b0, (cur_occ > 0)});
         check("err_cnt", 32'(err_cnt), 32'(cur_err));
         if (cur_occ == 0) begin
            check("empty_data", {16'b0, rx_data0, rx_data1}, 32'd0);
         end
         if (rx_pop && rx_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame", {16'b0, rx_data0, rx_data1}, 32'hDEAD_BEEF);
            end else begin
               logic [2*W-1:0] f;
               f = exp_q.pop_front();
               check("frame", {16'b0, rx_data0, rx_data1}, {16'b0, f});
            end
         end
      end
   end

   // Advance one clock; the model computes what the DUT should show afterwards.
   task automatic step();
      bit acc, pop_m, push_m, nh;
      int nerr, nocc;
      logic [W-1:0] nf;
      acc    = in_valid && ena && !rst && (cur_occ < 2);
      pop_m  = rx_pop && (cur_occ > 0);
      push_m = 0;
      nh     = have_first;
      nf     = first_beat;
      nerr   = cur_err;
      if (acc) begin
         if (!have_first) begin
            if (in_sof) begin nh = 1; nf = in_data; end
            else nerr = (cur_err < EMAX) ? cur_err + 1 : EMAX;
         end else if (in_sof) begin
            nerr = (cur_err < EMAX) ? cur_err + 1 : EMAX;
            nf   = in_data;
         end else begin
            push_m = 1;
            nh     = 0;
            exp_q.push_back({first_beat, in_data});
         end
      end else if (!ena) begin
         nh = 0;
      end
      nocc = cur_occ + int'(push_m) - int'(pop_m);
      @(posedge clk);
      if (rst) begin
         have_first = 0; first_beat = '0; cur_err = 0; cur_occ = 0;
         exp_q.delete();
      end else begin
         have_first = nh; first_beat = nf; cur_err = nerr; cur_occ = nocc;
      end
      #1;
   endtask

   // Offer one beat until the model says it was taken, with a cycle budget.
   task automatic send(input bit sof, input logic [W-1:0] d);
      bit taken;
      taken    = 0;
      in_valid = 1; in_sof = sof; in_data = d;
      for (int i = 0; i < 20 && !taken; i++) begin
         taken = ena && !rst && (cur_occ < 2);
         step();
      end
      if (!taken) check("send_timeout", 32'd0, 32'd1);
      in_valid = 0;
   endtask

   task automatic pulse_reset();
      rst = 1; in_valid = 0; rx_pop = 0;
      step();
      rst = 0;
   endtask

   task automatic pop_once();
      rx_pop = 1;
      step();
      rx_pop = 0;
   endtask

   initial begin
      rst = 1; ena = 0; in_valid = 0; in_data = '0; in_sof = 0; rx_pop = 0;
      step();
      started = 1;
      step();
      rst = 0;

      // Basic frame
      ena = 1;
      send(1, 8'h11); send(0, 8'h22);
      step();
      pop_once();
      step();

      // Backpressure: C0 stalls behind two held frames
      send(1, 8'hA0); send(0, 8'hA1); send(1, 8'hB0); send(0, 8'hB1);
      in_valid = 1; in_sof = 1; in_data = 8'hC0;
      step(); step();
      rx_pop = 1; step(); rx_pop = 0;
      send(1, 8'hC0); send(0, 8'hC1);
      pop_once(); pop_once(); pop_once();
      step();

      // Framing errors
      send(0, 8'h01); send(1, 8'h33); send(1, 8'h44); send(0, 8'h55);
      step();
      pop_once();

      // Saturation
      pulse_reset();
      ena = 1;
      for (int i = 0; i < EMAX + 3; i++) send(0, 8'(i));
      step();

      // Enable drop discards partial frame
      pulse_reset();
      ena = 1;
      send(1, 8'h66);
      ena = 0; step();
      ena = 1;
      send(0, 8'h77);
      step(); step();

      // Reset mid-operation
      pulse_reset();
      ena = 1;
      send(1, 8'h12); send(0, 8'h34); send(1, 8'h56);
      pulse_reset();
      step();
      send(1, 8'h78); send(0, 8'h9A);
      step();
      pop_once();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         ena      = ($urandom_range(0, 9) != 0);
         in_valid = ($urandom_range(0, 9) < 7);
         in_sof   = ($urandom_range(0, 9) < 4);
         in_data  = 8'($urandom);
         rx_pop   = ($urandom_range(0, 9) < 5);
         step();
      end
      rst = 0; in_valid = 0; ena = 0; rx_pop = 1;
      for (int i = 0; i < 4; i++) step();
      rx_pop = 0;
      step();
      check("drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
